// File: rtl/instruction_fetch_if.sv
// Bus bundle between the instruction fetch unit, the PC redirect source,
// instruction memory and the decode stage. master = fetch unit side.
interface instruction_fetch_if #(
    parameter int WORD_SIZE     = 16,
    parameter int MEM_ADDR_SIZE = 8,
    parameter int QUEUE_DEPTH   = 4
);
    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

    logic                     redirect_enable;
    logic [MEM_ADDR_SIZE-1:0] redirect_addr;
    logic                     mem_req;
    logic [MEM_ADDR_SIZE-1:0] mem_addr;
    logic                     mem_ack;
    logic [WORD_SIZE-1:0]     mem_rdata;
    logic                     instr_valid;
    logic [WORD_SIZE-1:0]     instr_data;
    logic [MEM_ADDR_SIZE-1:0] instr_addr;
    logic                     instr_ready;
    logic [CNT_W-1:0]         queue_count;

    modport master (
        input  redirect_enable, redirect_addr, mem_ack, mem_rdata, instr_ready,
        output mem_req, mem_addr, instr_valid, instr_data, instr_addr, queue_count
    );

    modport slave (
        output redirect_enable, redirect_addr, mem_ack, mem_rdata, instr_ready,
        input  mem_req, mem_addr, instr_valid, instr_data, instr_addr, queue_count
    );
endinterface

// File: rtl/instruction_fetch.sv
// Sequential instruction prefetcher with redirect handling and a small queue.
// Define FETCH_TRACE_EN to print fetch/push/drop/redirect trace messages.
//
// state     | meaning
// S_FETCH   | request words at fetch_addr while the queue has room
// S_STALL   | queue full, no request outstanding
// S_DISCARD | redirected with a request in flight; wait for its ack, drop it
module instruction_fetch #(
    parameter int WORD_SIZE     = 16,
    parameter int MEM_ADDR_SIZE = 8,
    parameter int QUEUE_DEPTH   = 4
) (
    input  logic                 clock,
    input  logic                 reset_enable_n,
    instruction_fetch_if.master  bus
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_FETCH, S_STALL, S_DISCARD} state_t;

    state_t                   r_state, w_state_next;
    logic                     r_mem_req, w_mem_req_next;
    logic [MEM_ADDR_SIZE-1:0] r_mem_addr, w_mem_addr_next;
    logic [MEM_ADDR_SIZE-1:0] r_fetch_addr, w_fetch_addr_next;
    logic [CNT_W-1:0]         r_count, w_count_next;
    logic [PTR_W-1:0]         r_rd_ptr, r_wr_ptr;
    logic [WORD_SIZE-1:0]     r_q_data [QUEUE_DEPTH];
    logic [MEM_ADDR_SIZE-1:0] r_q_addr [QUEUE_DEPTH];
    logic                     w_push, w_pop, w_flush;

    always_comb begin
        w_flush           = bus.redirect_enable;
        w_push            = r_mem_req && bus.mem_ack && (r_state == S_FETCH) && !w_flush;
        w_pop             = (r_count != '0) && bus.instr_ready && !w_flush;
        w_count_next      = w_flush ? '0 : r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        w_state_next      = r_state;
        w_mem_req_next    = r_mem_req;
        w_mem_addr_next   = r_mem_addr;
        w_fetch_addr_next = r_fetch_addr;

        if (w_flush) begin
            w_fetch_addr_next = bus.redirect_addr;
            // An unacked request cannot be withdrawn; keep it on the bus and drop its data.
            if (r_mem_req && !bus.mem_ack) begin
                w_state_next = S_DISCARD;
            end else begin
                w_state_next    = S_FETCH;
                w_mem_req_next  = 1'b1;
                w_mem_addr_next = bus.redirect_addr;
            end
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_push) w_fetch_addr_next = r_fetch_addr + MEM_ADDR_SIZE'(1);
                    if (w_count_next == CNT_W'(QUEUE_DEPTH)) begin
                        w_state_next   = S_STALL;
                        w_mem_req_next = 1'b0;
                    end else begin
                        w_mem_req_next  = 1'b1;
                        w_mem_addr_next = w_fetch_addr_next;
                    end
                end
                S_STALL: begin
                    if (w_count_next < CNT_W'(QUEUE_DEPTH)) begin
                        w_state_next    = S_FETCH;
                        w_mem_req_next  = 1'b1;
                        w_mem_addr_next = r_fetch_addr;
                    end
                end
                S_DISCARD: begin
                    if (bus.mem_ack) begin
                        w_state_next    = S_FETCH;
                        w_mem_req_next  = 1'b1;
                        w_mem_addr_next = r_fetch_addr;
                    end
                end
                default: begin
                    w_state_next   = S_FETCH;
                    w_mem_req_next = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_enable_n) begin
            r_state      <= S_FETCH;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_fetch_addr <= '0;
            r_count      <= '0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                r_q_data[i] <= '0;
                r_q_addr[i] <= '0;
            end
        end else begin
            r_state      <= w_state_next;
            r_mem_req    <= w_mem_req_next;
            r_mem_addr   <= w_mem_addr_next;
            r_fetch_addr <= w_fetch_addr_next;
            r_count      <= w_count_next;
            if (w_flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_q_data[r_wr_ptr] <= bus.mem_rdata;
                    r_q_addr[r_wr_ptr] <= r_mem_addr;
                    r_wr_ptr           <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    assign bus.mem_req     = r_mem_req;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.instr_valid = (r_count != '0);
    assign bus.instr_data  = r_q_data[r_rd_ptr];
    assign bus.instr_addr  = r_q_addr[r_rd_ptr];
    assign bus.queue_count = r_count;

`ifdef FETCH_TRACE_EN
    always @(posedge clock) begin
        if (reset_enable_n) begin
            if (w_flush) $display("Redirect to 0x%h", bus.redirect_addr);
            if (w_push) $display("Fetched 0x%h = 0x%h", r_mem_addr, bus.mem_rdata);
            else if (r_mem_req && bus.mem_ack) $display("Dropped 0x%h", r_mem_addr);
            if (w_mem_req_next && (!r_mem_req || bus.mem_ack)) $display("Fetching 0x%h", w_mem_addr_next);
        end
    end
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized and directed bench for instruction_fetch against a transaction-level model.
module tb_instruction_fetch;
    localparam int DEPTH = 4;

    logic clock = 1'b0;
    logic reset_enable_n;
    always #5 clock = ~clock;

    instruction_fetch_if #(.WORD_SIZE(16), .MEM_ADDR_SIZE(8), .QUEUE_DEPTH(DEPTH)) bus ();

    instruction_fetch #(.WORD_SIZE(16), .MEM_ADDR_SIZE(8), .QUEUE_DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset_enable_n (reset_enable_n),
        .bus            (bus.master)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] mem_img [256];

    // model: addresses waiting in the queue, next address to be pushed, pending drop
    logic [7:0] q_addr [$];
    logic [7:0] exp_fetch;
    logic [7:0] drop_addr;
    logic       pend_drop;
    logic       just_reset;
    logic       model_ok = 1'b0;
    logic [7:0] pop_log [$];

    int lat_mode;
    int lat_cur;
    int wait_cnt;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic set_lat(input int mode);
        lat_mode = mode;
        lat_cur  = (mode < 0) ? int'($urandom_range(0, 3)) : mode;
        wait_cnt = 0;
    endtask

    // Called at posedge+1; drives one cycle, checks at negedge, advances the model at the edge.
    task automatic cycle(input logic rst_n, input logic redir, input logic [7:0] raddr, input logic rdy);
        logic       ack, pop, req_now, exp_req;
        logic [7:0] maddr_now;
        req_now   = bus.mem_req;
        maddr_now = bus.mem_addr;
        ack       = req_now && (wait_cnt >= lat_cur);
        reset_enable_n      = rst_n;
        bus.redirect_enable = redir;
        bus.redirect_addr   = raddr;
        bus.instr_ready     = rdy;
        bus.mem_ack         = ack;
        bus.mem_rdata       = ack ? mem_img[maddr_now] : 16'($urandom);
        @(negedge clock);
        if (model_ok) begin
            exp_req = just_reset ? 1'b0 : (pend_drop || (q_addr.size() < DEPTH));
            check_eq("mem_req", {31'b0, bus.mem_req}, {31'b0, exp_req});
            if (just_reset) check_eq("mem_addr_rst", {24'b0, bus.mem_addr}, 32'h0);
            else if (bus.mem_req)
                check_eq("mem_addr", {24'b0, bus.mem_addr}, {24'b0, pend_drop ? drop_addr : exp_fetch});
            check_eq("instr_valid", {31'b0, bus.instr_valid}, {31'b0, q_addr.size() != 0});
            check_eq("queue_count", {29'b0, bus.queue_count}, q_addr.size());
            if (q_addr.size() != 0) begin
                check_eq("instr_addr", {24'b0, bus.instr_addr}, {24'b0, q_addr[0]});
                check_eq("instr_data", {16'b0, bus.instr_data}, {16'b0, mem_img[q_addr[0]]});
            end
        end
        pop = rdy && (q_addr.size() != 0);
        if (!rst_n) begin
            q_addr.delete();
            exp_fetch  = 8'h00;
            pend_drop  = 1'b0;
            just_reset = 1'b1;
            model_ok   = 1'b1;
        end else if (model_ok) begin
            just_reset = 1'b0;
            if (redir) begin
                q_addr.delete();
                if (req_now && !ack) begin
                    if (!pend_drop) drop_addr = exp_fetch;
                    pend_drop = 1'b1;
                end else begin
                    pend_drop = 1'b0;
                end
                exp_fetch = raddr;
            end else begin
                if (pop) pop_log.push_back(q_addr.pop_front());
                if (ack) begin
                    if (pend_drop) pend_drop = 1'b0;
                    else begin
                        q_addr.push_back(exp_fetch);
                        exp_fetch = exp_fetch + 8'd1;
                    end
                end
            end
        end
        if (req_now && !ack) wait_cnt++;
        else begin
            wait_cnt = 0;
            lat_cur  = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        pop_log.delete();
    endtask

    initial begin
        int found;
        int n2;
        int rdy_pct;
        logic [7:0] exp_seq [4];
        for (int i = 0; i < 256; i++) mem_img[i] = 16'($urandom);
        reset_enable_n      = 1'b0;
        bus.redirect_enable = 1'b0;
        bus.redirect_addr   = 8'h00;
        bus.instr_ready     = 1'b0;
        bus.mem_ack         = 1'b0;
        bus.mem_rdata       = 16'h0;
        set_lat(0);
        @(posedge clock);
        #1;

        // zero-wait memory, always ready: addresses 0..3 stream out
        do_reset();
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1);
        check_eq("t1_pops", pop_log.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < pop_log.size()) check_eq("t1_pop_addr", {24'b0, pop_log[i]}, i);

        // decode stalled: queue fills to 4, then one pop restarts fetch
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'h00, 1'b0);
        check_eq("t2_full_count", {29'b0, bus.queue_count}, DEPTH);
        check_eq("t2_stall_req", {31'b0, bus.mem_req}, 32'd0);
        cycle(1'b1, 1'b0, 8'h00, 1'b1);
        check_eq("t2_head_addr", {24'b0, bus.instr_addr}, 32'd1);
        check_eq("t2_req_resume", {31'b0, bus.mem_req}, 32'd1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'h00, 1'b0);

        // slow memory, redirect while the addr-2 request is in flight
        set_lat(2);
        do_reset();
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            if (bus.mem_req && bus.mem_addr == 8'h02) found = 1;
            else cycle(1'b1, 1'b0, 8'h00, 1'b1);
        end
        check_eq("t3_addr2_issued", found, 1);
        cycle(1'b1, 1'b0, 8'h00, 1'b1);
        pop_log.delete();
        cycle(1'b1, 1'b1, 8'h40, 1'b1);
        for (int i = 0; i < 15; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1);
        check_eq("t3_popped_any", {31'b0, pop_log.size() > 0}, 32'd1);
        if (pop_log.size() > 0) check_eq("t3_first_addr", {24'b0, pop_log[0]}, 32'h40);
        n2 = 0;
        foreach (pop_log[i]) if (pop_log[i] == 8'h02) n2++;
        check_eq("t3_no_addr2", n2, 0);

        // redirect coinciding with ack and pop, three entries queued
        set_lat(0);
        do_reset();
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            if (bus.queue_count == 3) found = 1;
            else cycle(1'b1, 1'b0, 8'h00, 1'b0);
        end
        check_eq("t4_count3", found, 1);
        cycle(1'b1, 1'b1, 8'h10, 1'b1);
        check_eq("t4_count_clear", {29'b0, bus.queue_count}, 32'd0);
        check_eq("t4_req_addr", {23'b0, bus.mem_req, bus.mem_addr}, {23'b0, 1'b1, 8'h10});
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1);

        // address wrap-around
        cycle(1'b1, 1'b1, 8'hFE, 1'b1);
        pop_log.delete();
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1);
        exp_seq[0] = 8'hFE; exp_seq[1] = 8'hFF; exp_seq[2] = 8'h00; exp_seq[3] = 8'h01;
        check_eq("t5_pops", {31'b0, pop_log.size() >= 4}, 32'd1);
        for (int i = 0; i < 4; i++)
            if (i < pop_log.size()) check_eq("t5_wrap_addr", {24'b0, pop_log[i]}, {24'b0, exp_seq[i]});

        // reset with entries queued, and reset during a discard
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'h00, 1'b0);
        check_eq("t6_count2", {29'b0, bus.queue_count}, 32'd2);
        do_reset();
        check_eq("t6_rst_a", {20'b0, bus.mem_req, bus.mem_addr, bus.instr_valid, bus.queue_count},
                 32'd0);
        set_lat(3);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'h00, 1'b0);
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            if (bus.mem_req && wait_cnt == 0) found = 1;
            else cycle(1'b1, 1'b0, 8'h00, 1'b1);
        end
        check_eq("t6_req_seen", found, 1);
        cycle(1'b1, 1'b1, 8'h80, 1'b1);
        check_eq("t6_discard", {31'b0, pend_drop}, 32'd1);
        do_reset();
        check_eq("t6_rst_b", {20'b0, bus.mem_req, bus.mem_addr, bus.instr_valid, bus.queue_count},
                 32'd0);
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1);
        check_eq("t6_restart_pops", {31'b0, pop_log.size() > 0}, 32'd1);
        if (pop_log.size() > 0) check_eq("t6_restart_addr", {24'b0, pop_log[0]}, 32'd0);

        // randomized traffic
        set_lat(-1);
        rdy_pct = 60;
        for (int i = 0; i < 2000; i++) begin
            logic r_n, rd, rdy;
            if (i % 100 == 0) rdy_pct = (($urandom_range(0, 2) == 0) ? 15 : (($urandom_range(0, 1) == 0) ? 60 : 95));
            r_n = ($urandom_range(0, 199) != 0);
            rd  = ($urandom_range(0, 99) < 4);
            rdy = ($urandom_range(0, 99) < rdy_pct);
            cycle(r_n, rd, 8'($urandom), rdy);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
